// File: rtl/adder_if.sv
// Operand/result bundle for the registered adder/subtractor.
// The master drives operands and samples results; the slave is the adder itself.
interface adder_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             in_valid;
  logic [WIDTH-1:0] y;
  logic             co;
  logic             ovf;
  logic             out_valid;

  modport master (
    output a, b, ci, sub, in_valid,
    input  y, co, ovf, out_valid
  );

  modport slave (
    input  a, b, ci, sub, in_valid,
    output y, co, ovf, out_valid
  );
endinterface

// File: rtl/adder.sv
// Registered WIDTH-bit ripple-carry adder/subtractor: {co, y} = a + (sub ? ~b : b) + ci.
// One-cycle latency, one operation per clock, synchronous active-high reset.
module adder #(
  parameter int unsigned WIDTH = 1
) (
  input logic    clk,
  input logic    rst,
  adder_if.slave bus
);

  logic [WIDTH-1:0] sum_c;
  logic             carry_out_c;
  logic             carry_msb_c;

  logic [WIDTH-1:0] y_d, y_q;
  logic             co_d, co_q;
  logic             ovf_d, ovf_q;
  logic             out_valid_d, out_valid_q;

  // Chain of full-adder cells; carry_msb_c is the carry into the MSB cell.
  always_comb begin : ripple
    logic [WIDTH-1:0] bb;
    logic             c;
    bb          = bus.sub ? ~bus.b : bus.b;
    c           = bus.ci;
    sum_c       = '0;
    carry_msb_c = bus.ci;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      carry_msb_c = c;
      sum_c[i]    = bus.a[i] ^ bb[i] ^ c;
      c           = (bus.a[i] & bb[i]) | (c & (bus.a[i] ^ bb[i]));
    end
    carry_out_c = c;
  end

  always_comb begin : next_state
    y_d         = y_q;
    co_d        = co_q;
    ovf_d       = ovf_q;
    out_valid_d = bus.in_valid;
    if (bus.in_valid) begin
      y_d   = sum_c;
      co_d  = carry_out_c;
      ovf_d = carry_out_c ^ carry_msb_c;
    end
  end

  always_ff @(posedge clk) begin : out_reg
    if (rst) begin
      y_q         <= '0;
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      co_q        <= co_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.y         = y_q;
  assign bus.co        = co_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder at WIDTH = 1, 8 and 64 against an arithmetic reference model.
module tb_adder;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  adder_if #(.WIDTH(1))  if1 ();
  adder_if #(.WIDTH(8))  if8 ();
  adder_if #(.WIDTH(64)) if64 ();

  adder #(.WIDTH(1))  u_dut1  (.clk(clk), .rst(rst), .bus(if1.slave));
  adder #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
  adder #(.WIDTH(64)) u_dut64 (.clk(clk), .rst(rst), .bus(if64.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected register contents per instance (index 0: W=1, 1: W=8, 2: W=64)
  logic [63:0] e_y   [3];
  logic        e_co  [3];
  logic        e_ovf [3];
  logic        e_v   [3];
  int          wid   [3];

  // Unbounded-precision sum, then signed overflow from operand/result signs.
  function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic ci, input logic sub, input int w);
    logic [63:0] mask, am, bm, y;
    logic [64:0] full;
    logic        co, ovf;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    am   = a & mask;
    bm   = (sub ? ~b : b) & mask;
    full = {1'b0, am} + {1'b0, bm} + {64'd0, ci};
    y    = full[63:0] & mask;
    co   = full[w];
    ovf  = (am[w-1] == bm[w-1]) && (y[w-1] != am[w-1]);
    return {ovf, co, y};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] obs_y(input int k);
    if (k == 0) return 64'(if1.y);
    if (k == 1) return 64'(if8.y);
    return if64.y;
  endfunction

  function automatic logic [2:0] obs_flags(input int k);
    if (k == 0) return {if1.co, if1.ovf, if1.out_valid};
    if (k == 1) return {if8.co, if8.ovf, if8.out_valid};
    return {if64.co, if64.ovf, if64.out_valid};
  endfunction

  // Drive all instances, clock once, update the scoreboard and compare.
  task automatic step(input logic [63:0] a, input logic [63:0] b, input logic ci,
                      input logic sub, input logic v, input logic r);
    logic [65:0] m;
    logic [2:0]  f;
    if1.a  = a[0:0];  if1.b  = b[0:0];
    if8.a  = a[7:0];  if8.b  = b[7:0];
    if64.a = a;       if64.b = b;
    if1.ci = ci;  if8.ci = ci;  if64.ci = ci;
    if1.sub = sub; if8.sub = sub; if64.sub = sub;
    if1.in_valid = v; if8.in_valid = v; if64.in_valid = v;
    rst = r;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        e_y[k] = '0; e_co[k] = 1'b0; e_ovf[k] = 1'b0; e_v[k] = 1'b0;
      end else begin
        e_v[k] = v;
        if (v) begin
          m = model(a, b, ci, sub, wid[k]);
          e_y[k] = m[63:0]; e_co[k] = m[64]; e_ovf[k] = m[65];
        end
      end
      f = obs_flags(k);
      check($sformatf("y_w%0d", wid[k]), obs_y(k), e_y[k]);
      check($sformatf("co_w%0d", wid[k]), 64'(f[2]), 64'(e_co[k]));
      check($sformatf("ovf_w%0d", wid[k]), 64'(f[1]), 64'(e_ovf[k]));
      check($sformatf("out_valid_w%0d", wid[k]), 64'(f[0]), 64'(e_v[k]));
    end
  endtask

  logic [1:0]  fa_tab [8];
  logic [63:0] ra, rb;
  logic [7:0]  held_y;

  initial begin
    checks   = 0;
    failures = 0;
    wid[0] = 1; wid[1] = 8; wid[2] = 64;
    for (int k = 0; k < 3; k++) begin
      e_y[k] = '0; e_co[k] = 1'b0; e_ovf[k] = 1'b0; e_v[k] = 1'b0;
    end
    fa_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    rst = 1'b1;

    // Reset overrides in_valid
    step(64'h5, 64'h3, 1'b1, 1'b0, 1'b1, 1'b1);
    step(64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_y8", 64'(if8.y), 64'h0);

    // WIDTH=1 full-adder truth table
    for (int i = 0; i < 8; i++) begin
      step({63'd0, i[2]}, {63'd0, i[1]}, i[0], 1'b0, 1'b1, 1'b0);
      check($sformatf("fa_%0d", i), 64'({if1.co, if1.y}), 64'(fa_tab[i]));
    end

    // WIDTH=8 directed boundaries
    step(64'hFF, 64'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    check("wrap_y", 64'(if8.y), 64'h00);
    check("wrap_co_ovf", 64'({if8.co, if8.ovf}), 64'b10);
    step(64'h7F, 64'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    check("povf_y", 64'(if8.y), 64'h80);
    check("povf_co_ovf", 64'({if8.co, if8.ovf}), 64'b01);
    step(64'h05, 64'h07, 1'b1, 1'b1, 1'b1, 1'b0);
    check("sub_y", 64'(if8.y), 64'hFE);
    check("sub_co_ovf", 64'({if8.co, if8.ovf}), 64'b00);
    step(64'h80, 64'h01, 1'b1, 1'b1, 1'b1, 1'b0);
    check("sub_ovf_y", 64'(if8.y), 64'h7F);
    check("sub_ovf", 64'(if8.ovf), 64'h1);
    step(64'h10, 64'h03, 1'b0, 1'b1, 1'b1, 1'b0);
    check("sub_nc_y", 64'(if8.y), 64'h0C);

    // Hold: drop in_valid and change operands
    step(64'h12, 64'h34, 1'b0, 1'b0, 1'b1, 1'b0);
    held_y = if8.y;
    check("hold_load", 64'(held_y), 64'h46);
    step(64'hAA, 64'h77, 1'b1, 1'b1, 1'b0, 1'b0);
    step(64'h01, 64'hFE, 1'b1, 1'b0, 1'b0, 1'b0);
    check("hold_y", 64'(if8.y), 64'(held_y));
    check("hold_valid", 64'(if8.out_valid), 64'h0);

    // Mid-stream reset discards the sampled op; next valid input after release
    step(64'h21, 64'h22, 1'b0, 1'b0, 1'b1, 1'b0);
    step(64'hFF, 64'hFF, 1'b1, 1'b0, 1'b1, 1'b1);
    check("midrst_y", 64'(if8.y), 64'h00);
    step(64'h03, 64'h04, 1'b0, 1'b0, 1'b1, 1'b0);
    check("post_rst_y", 64'(if8.y), 64'h07);
    check("post_rst_valid", 64'(if8.out_valid), 64'h1);

    // 64-bit extremes
    step({64{1'b1}}, 64'h1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("w64_wrap", 64'({if64.co, if64.y[0]}), 64'b10);
    step(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("w64_ovf", 64'(if64.ovf), 64'h1);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      step(ra, rb, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 31) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder.md
# adder

Registered WIDTH-bit ripple-carry adder/subtractor built from a chain of 1-bit full-adder cells. Computes {co, y} = a + b + ci, or a + ~b + ci in subtract mode, and registers the result once per clock. It is the arithmetic primitive of the adder/subtractor datapath. With WIDTH = 1 and sub = 0 it reduces to a clocked 1-bit full adder.

## Interface
- WIDTH, 1: operand and sum width in bits; legal values are 1 to 64.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- ci  input  1  carry in to bit 0.
- sub  input  1  1 = subtract mode; bit 0 receives ci and every b bit is inverted.
- in_valid  input  1  qualifies a, b, ci and sub for this cycle.
- co  output  1  registered carry out of the MSB cell.
- y  output  WIDTH  registered sum.
- ovf  output  1  registered signed overflow.
- out_valid  output  1  y, co and ovf hold a new result.
- One clock; reset is synchronous and active-high (ports clk, rst).

## Operation
- Operand conditioning: bb = sub ? ~b : b. True subtraction a - b requires sub = 1 and ci = 1. With sub = 1 and ci = 0 the result is a - b - 1.
- Cell i: s_i = a_i ^ bb_i ^ c_i and c_(i+1) = (a_i & bb_i) | (c_i & (a_i ^ bb_i)). c_0 = ci.
- Full result: {co, y} = a + bb + ci, exactly WIDTH+1 bits, with no truncation of the carry.
- ovf = c_WIDTH ^ c_(WIDTH-1), which is signed overflow of the two's-complement sum. For WIDTH = 1, c_0 = ci, so ovf = co ^ ci.
- Register update:
  - When in_valid = 1, y, co and ovf load the combinational result on the rising edge.
  - When in_valid = 0, y, co and ovf hold their previous values.
- out_valid <= in_valid every cycle.
- Combinational logic has no state; the only storage is the output register.

## Timing
- Latency is 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Throughput is one operation per clock, with no back-pressure.
- Reset:
  - When rst = 1 at a rising edge, y = 0, co = 0, ovf = 0 and out_valid = 0 after that edge.
  - Reset overrides in_valid.
  - A reset asserted mid-stream discards the operation sampled on that edge.
  - The first valid result after reset needs in_valid = 1 at an edge with rst = 0.
- Wrap-around: all-ones + 1 gives y = 0 and co = 1; this is not an error.
- Changing sub and the operands in the same cycle is legal because all inputs are sampled together.
- The ripple path runs through WIDTH cells. The clock period must cover WIDTH carry delays plus setup time.

## Test plan
- WIDTH=1, sub=0, in_valid=1: apply all 8 combinations of (a, b, ci), 000 through 111.
  - Expected one cycle later, as (co, y): 000→00, 001→01, 010→01, 011→10, 100→01, 101→10, 110→10, 111→11.
- WIDTH=8, sub=0: a=8'hFF, b=8'h01, ci=0 → y=8'h00, co=1, ovf=0.
- WIDTH=8, sub=0: a=8'h7F, b=8'h01, ci=0 → y=8'h80, co=0, ovf=1.
- WIDTH=8, sub=1, ci=1 (subtraction):
  - a=8'h05, b=8'h07 → y=8'hFE, co=0, ovf=0.
  - a=8'h80, b=8'h01 → y=8'h7F, ovf=1.
- Hold behaviour: load a result, then drop in_valid and change the operands → y, co and ovf are unchanged and out_valid=0.
- Reset mid-stream: assert rst together with in_valid=1 → after that edge all outputs are 0.
  - Release rst → the next valid input appears one cycle later.
